fe_pow: RTL

- Sequencer that computes out = a^EXPONENT mod p, with p = 2^255-19, by driving an external femul (field multiplier) through a request/response interface.
- Default EXPONENT = p-2, so the default block is the field inverter that feeds femul in the point-arithmetic datapath.
- Uses left-to-right square-and-multiply. It issues one femul operation at a time and holds the running result in an internal register.

---
 rtl/fe_pkg.sv | 30 +++
 rtl/fe_pow.sv | 118 +++++++++++
 2 files changed

// File: rtl/fe_pkg.sv
// Shared field constants for GF(2^255-19) and the fe_pow sequencer state encoding.
package fe_pkg;

  localparam int FE_BITS = 255;

  // p = 2^255 - 19 : all ones except the low five bits 01101
  localparam logic [FE_BITS-1:0] FE_P         = {{250{1'b1}}, 5'b01101};
  // p - 2 : exponent that turns a^e mod p into the field inverse
  localparam logic [FE_BITS-1:0] FE_P_MINUS_2 = {{250{1'b1}}, 5'b01011};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SQ_ISSUE,
    ST_SQ_WAIT,
    ST_MUL_ISSUE,
    ST_MUL_WAIT,
    ST_FINISH
  } fe_pow_state_e;

  // Index of the highest set bit; 0 for an all-zero vector.
  function automatic int fe_msb(input logic [FE_BITS-1:0] v);
    int m;
    m = 0;
    for (int i = 0; i < FE_BITS; i++) begin
      if (v[i]) m = i;
    end
    return m;
  endfunction

endpackage

// File: rtl/fe_pow.sv
// Left-to-right square-and-multiply controller computing a^EXPONENT mod p.
// The field multiplier lives outside this block; fe_pow only sequences it
// through a start/done handshake, one operation in flight at a time.
module fe_pow
  import fe_pkg::*;
#(
  parameter logic [FE_BITS-1:0] EXPONENT = FE_P_MINUS_2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [FE_BITS-1:0] a,
  output logic               busy,
  output logic               done,
  output logic [FE_BITS-1:0] out,
  output logic               mul_start,
  output logic [FE_BITS-1:0] mul_a,
  output logic [FE_BITS-1:0] mul_b,
  input  logic               mul_done,
  input  logic [FE_BITS-1:0] mul_out
);

  localparam int               EXP_TOP     = fe_msb(EXPONENT);
  localparam logic [7:0]       EXP_TOP_IDX = 8'(EXP_TOP);
  localparam logic [FE_BITS-1:0] FE_ONE    = {{(FE_BITS-1){1'b0}}, 1'b1};
  // A zero exponent yields 1 regardless of a; seed the accumulator with it.
  localparam logic             EXP_ZERO    = (EXPONENT == '0);

  fe_pow_state_e      state_q;
  logic [7:0]         idx_q;
  logic [FE_BITS-1:0] base_q;
  logic [FE_BITS-1:0] acc_q;
  logic [FE_BITS-1:0] out_q;
  logic               done_q;
  logic               busy_q;
  logic               mul_start_q;
  logic [FE_BITS-1:0] mul_a_q;
  logic [FE_BITS-1:0] mul_b_q;
  logic               mul_cpl_d;
  logic               exp_bit_d;

  // mul_done may still be high from the previous product while our start pulse
  // is on the wire, so completion only counts once the pulse has dropped.
  assign mul_cpl_d = mul_done && !mul_start_q;
  assign exp_bit_d = EXPONENT[idx_q];

  // Sequencer: one state per issue/wait step, all outputs registered.
  always_ff @(posedge clock) begin
    mul_start_q <= 1'b0;
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      out_q       <= '0;
      mul_start_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            base_q  <= a;
            acc_q   <= EXP_ZERO ? FE_ONE : a;
            idx_q   <= EXP_TOP_IDX;
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= (EXP_TOP == 0) ? ST_FINISH : ST_SQ_ISSUE;
          end
        end
        ST_SQ_ISSUE: begin
          mul_start_q <= 1'b1;
          mul_a_q     <= acc_q;
          mul_b_q     <= acc_q;
          idx_q       <= idx_q - 8'd1;
          state_q     <= ST_SQ_WAIT;
        end
        ST_SQ_WAIT: begin
          if (mul_cpl_d) begin
            acc_q <= mul_out;
            if (exp_bit_d) begin
              state_q <= ST_MUL_ISSUE;
            end else if (idx_q == 8'd0) begin
              state_q <= ST_FINISH;
            end else begin
              state_q <= ST_SQ_ISSUE;
            end
          end
        end
        ST_MUL_ISSUE: begin
          mul_start_q <= 1'b1;
          mul_a_q     <= acc_q;
          mul_b_q     <= base_q;
          state_q     <= ST_MUL_WAIT;
        end
        ST_MUL_WAIT: begin
          if (mul_cpl_d) begin
            acc_q   <= mul_out;
            state_q <= (idx_q == 8'd0) ? ST_FINISH : ST_SQ_ISSUE;
          end
        end
        ST_FINISH: begin
          out_q   <= acc_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign out       = out_q;
  assign mul_start = mul_start_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;

endmodule
